// File: rtl/mod_addsub_serial_if.sv
// Operand/result handshake bundle for mod_addsub_serial.
interface mod_addsub_serial_if #(
  parameter int WIDTH = 256
);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op, x, y, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, x, y, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mod_addsub_serial.sv
// Limb-serial modular adder/subtractor: raw sum/difference over NLIMB cycles,
// then one correction pass against MOD over another NLIMB cycles.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | raw = x +/- y, one limb per cycle, LSB first
// CORR  | cand = raw -/+ MOD, one limb per cycle; pick raw or cand at the end
// DONE  | result presented, out_valid=1 until out_ready
module mod_addsub_serial #(
  parameter int               WIDTH = 256,
  parameter int               LIMB  = 64,
  parameter logic [WIDTH-1:0] MOD   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input logic                clk,
  input logic                reset,
  mod_addsub_serial_if.slave bus
);
  localparam int NLIMB = WIDTH / LIMB;
  localparam int IW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NLIMB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] CORR = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] xr;     // x operand, shifted down one limb per CALC cycle
  logic [WIDTH-1:0] yr;     // y operand in CALC, then MOD in CORR
  logic [WIDTH-1:0] raw;    // raw sum/difference; rotates in CORR so it ends unchanged
  logic [WIDTH-1:0] cand;   // corrected candidate, filled from the top
  logic [WIDTH-1:0] res;
  logic             opr;
  logic             c;      // running carry/borrow of the current pass
  logic             c1;     // final carry/borrow of the CALC pass
  logic [IW-1:0]    idx;

  logic [LIMB-1:0]  a_l;
  logic [LIMB-1:0]  b_l;
  logic             sub_l;
  logic [LIMB:0]    lsum;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] raw_rot;
  logic [WIDTH-1:0] cand_in;
  logic             use_cand;

  // Shared limb adder: CALC does x +/- y, CORR does raw -/+ MOD (opposite sense).
  always_comb begin
    a_l   = (state == CORR) ? raw[LIMB-1:0] : xr[LIMB-1:0];
    b_l   = yr[LIMB-1:0];
    sub_l = (state == CORR) ? ~opr : opr;
    if (sub_l)
      lsum = {1'b0, a_l} - {1'b0, b_l} - {{LIMB{1'b0}}, c};
    else
      lsum = {1'b0, a_l} + {1'b0, b_l} + {{LIMB{1'b0}}, c};
    raw_in   = (raw >> LIMB) | (WIDTH'(lsum[LIMB-1:0]) << (WIDTH - LIMB));
    raw_rot  = (raw >> LIMB) | (raw << (WIDTH - LIMB));
    cand_in  = (cand >> LIMB) | (WIDTH'(lsum[LIMB-1:0]) << (WIDTH - LIMB));
    // add: subtract MOD on overflow or when raw >= MOD (no final borrow)
    // sub: add MOD back only when the raw difference borrowed
    use_cand = opr ? c1 : (c1 | ~lsum[LIMB]);
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      xr    <= '0;
      yr    <= '0;
      raw   <= '0;
      cand  <= '0;
      res   <= '0;
      opr   <= 1'b0;
      c     <= 1'b0;
      c1    <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xr    <= bus.x;
            yr    <= bus.y;
            opr   <= bus.op;
            idx   <= '0;
            c     <= 1'b0;
            c1    <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          raw <= raw_in;
          xr  <= xr >> LIMB;
          if (idx == LAST) begin
            idx   <= '0;
            c     <= 1'b0;
            c1    <= lsum[LIMB];
            yr    <= MOD;
            state <= CORR;
          end else begin
            idx <= idx + IW'(1);
            c   <= lsum[LIMB];
            yr  <= yr >> LIMB;
          end
        end
        CORR: begin
          raw  <= raw_rot;
          cand <= cand_in;
          yr   <= yr >> LIMB;
          c    <= lsum[LIMB];
          if (idx == LAST) begin
            idx   <= '0;
            res   <= use_cand ? cand_in : raw_rot;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res;
endmodule
